cdb_rr_arbiter: RTL and testbench

- Parametrised successor to the fixed CDB arbiter: NUM_REQ functional-unit result producers compete for NUM_CDB broadcast lanes.
- Each requester gets a one-entry holding slot with valid/ready backpressure, so an ungranted result is never lost.
- A round-robin pointer guarantees starvation freedom; a squash input flushes pending results on mispredict.
- Registered lanes drive the physical register file, map table and EX forwarding.

---
 rtl/cdb_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_cdb_rr_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: round-robin arbiter of NUM_REQ result producers onto NUM_CDB
// registered common-data-bus lanes.
//
// Each requester owns a one-entry holding slot (valid/ready handshake). Every
// cycle, starting at rr_ptr, the first NUM_CDB valid slots with a non-zero tag
// are granted to lanes 0..NUM_CDB-1 in scan order. Granted slots may reload on
// the same edge. Tag-0 slots are dropped one cycle after loading. squash
// flushes all slots and lanes.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/tag/data    per-requester result (packed, requester i at slice i)
//   req_ready             slot i can accept this cycle
//   squash                synchronous flush of slots and lanes
//   cdb_valid/tag/data    registered broadcast lanes (lane k at slice k)
//   pending_count         number of occupied holding slots
module cdb_rr_arbiter #(
   parameter int unsigned NUM_REQ = 6,
   parameter int unsigned NUM_CDB = 2,
   parameter int unsigned TAG_W   = 6,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          squash,
   output logic [NUM_CDB-1:0]            cdb_valid,
   output logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
   output logic [NUM_CDB*DATA_W-1:0]     cdb_data,
   output logic [$clog2(NUM_REQ+1)-1:0]  pending_count
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);

   if (NUM_REQ < 2 || NUM_CDB < 1 || NUM_CDB > NUM_REQ) begin : g_bad_params
      $error("cdb_rr_arbiter: need NUM_REQ >= 2 and 1 <= NUM_CDB <= NUM_REQ");
   end

   logic [NUM_REQ-1:0] hold_valid;
   logic [TAG_W-1:0]   hold_tag  [NUM_REQ];
   logic [DATA_W-1:0]  hold_data [NUM_REQ];
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   ptr_next;
   logic [NUM_REQ-1:0] live;
   logic [NUM_REQ-1:0] gnt;
   logic [PTR_W-1:0]   lane_sel  [NUM_CDB];
   logic [NUM_CDB-1:0] lane_used;

   // Only slots with a real destination take part in arbitration.
   always_comb begin
      live = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         live[i] = hold_valid[i] && (hold_tag[i] != '0);
      end
   end

   // Lane k takes the first live, not yet granted slot in rotated order, so
   // lower lanes always get earlier slots. The pointer follows the last grant.
   always_comb begin
      logic             found;
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      gnt       = '0;
      lane_used = '0;
      ptr_next  = rr_ptr;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         lane_sel[k] = '0;
      end
      for (int k = 0; k < NUM_CDB; k++) begin
         found = 1'b0;
         for (int j = 0; j < NUM_REQ; j++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
               sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && live[idx] && !gnt[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               lane_sel[k]  = idx;
               lane_used[k] = 1'b1;
               ptr_next     = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
         end
      end
   end

   // A granted slot frees this cycle, enabling back-to-back reloads.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = !squash && (!hold_valid[i] || gnt[i]);
      end
   end

   always_comb begin
      pending_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pending_count = pending_count + CNT_W'(hold_valid[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold_tag[i]  <= '0;
            hold_data[i] <= '0;
         end
         rr_ptr    <= '0;
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (squash) begin
               hold_valid[i] <= 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
               hold_valid[i] <= 1'b1;
               hold_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
               hold_data[i]  <= req_data[i*DATA_W +: DATA_W];
            end else if (gnt[i] || (hold_valid[i] && hold_tag[i] == '0)) begin
               // Granted, or a tag-0 result that is dropped without a lane.
               hold_valid[i] <= 1'b0;
            end
         end
         for (int k = 0; k < NUM_CDB; k++) begin
            if (!squash && lane_used[k]) begin
               cdb_valid[k]                  <= 1'b1;
               cdb_tag[k*TAG_W +: TAG_W]     <= hold_tag[lane_sel[k]];
               cdb_data[k*DATA_W +: DATA_W]  <= hold_data[lane_sel[k]];
            end else begin
               cdb_valid[k]                  <= 1'b0;
               cdb_tag[k*TAG_W +: TAG_W]     <= '0;
               cdb_data[k*DATA_W +: DATA_W]  <= '0;
            end
         end
         if (!squash) begin
            rr_ptr <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Self-checking bench for cdb_rr_arbiter: directed scenarios plus randomized
// traffic compared against a slot/queue reference model.
module tb_cdb_rr_arbiter;

   localparam int NR = 6;
   localparam int NC = 2;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int CW = 3;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR*TW-1:0]  req_tag;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              squash;
   logic [NC-1:0]     cdb_valid;
   logic [NC*TW-1:0]  cdb_tag;
   logic [NC*DW-1:0]  cdb_data;
   logic [CW-1:0]     pending_count;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_rr_arbiter #(
      .NUM_REQ (NR),
      .NUM_CDB (NC),
      .TAG_W   (TW),
      .DATA_W  (DW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_tag       (req_tag),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .squash        (squash),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_data      (cdb_data),
      .pending_count (pending_count)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   bit            mv [NR];
   logic [TW-1:0] mt [NR];
   logic [DW-1:0] md [NR];
   int            mptr;
   bit            lv [NC];
   logic [TW-1:0] lt [NC];
   logic [DW-1:0] ld [NC];
   int            picks[$];

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) begin
         mv[i] = 0; mt[i] = '0; md[i] = '0;
      end
      for (int k = 0; k < NC; k++) begin
         lv[k] = 0; lt[k] = '0; ld[k] = '0;
      end
      mptr = 0;
   endfunction

   // Walk the ring from the pointer, collecting broadcastable slots in order.
   function automatic void model_pick();
      picks.delete();
      for (int j = 0; j < NR; j++) begin
         int i;
         i = (mptr + j) % NR;
         if (mv[i] && mt[i] != 0 && picks.size() < NC) picks.push_back(i);
      end
   endfunction

   function automatic bit picked(input int i);
      foreach (picks[p]) if (picks[p] == i) return 1;
      return 0;
   endfunction

   function automatic logic [NR-1:0] model_ready();
      logic [NR-1:0] r;
      model_pick();
      for (int i = 0; i < NR; i++) r[i] = !squash && (!mv[i] || picked(i));
      return r;
   endfunction

   function automatic int model_pending();
      int c;
      c = 0;
      for (int i = 0; i < NR; i++) c += int'(mv[i]);
      return c;
   endfunction

   function automatic void model_edge();
      bit rdy [NR];
      bit g   [NR];
      model_pick();
      for (int i = 0; i < NR; i++) begin
         g[i]   = picked(i);
         rdy[i] = !squash && (!mv[i] || g[i]);
      end
      if (squash) begin
         for (int i = 0; i < NR; i++) mv[i] = 0;
         for (int k = 0; k < NC; k++) begin
            lv[k] = 0; lt[k] = '0; ld[k] = '0;
         end
      end else begin
         for (int k = 0; k < NC; k++) begin
            if (k < picks.size()) begin
               lv[k] = 1; lt[k] = mt[picks[k]]; ld[k] = md[picks[k]];
            end else begin
               lv[k] = 0; lt[k] = '0; ld[k] = '0;
            end
         end
         if (picks.size() > 0) mptr = (picks[picks.size()-1] + 1) % NR;
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && rdy[i]) begin
               mv[i] = 1;
               mt[i] = req_tag[i*TW +: TW];
               md[i] = req_data[i*DW +: DW];
            end else if (g[i] || (mv[i] && mt[i] == 0)) begin
               mv[i] = 0;
            end
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_tag   = '0;
      req_data  = '0;
      squash    = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_tag[i*TW +: TW]   = t;
      req_data[i*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      model_reset();
      #4;
      reset = 1'b1;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_tests++;
      if (req_ready !== 6'h3f) begin
         n_fail++; $display("FAIL reset_ready_init: got %b want 111111", req_ready);
      end
      n_tests++;
      if (pending_count !== 3'd0 || cdb_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle_init: pending %0d valid %b want 0 00", pending_count, cdb_valid);
      end
      for (int i = 0; i < 5; i++) set_req(i, TW'(i + 1), DW'(32'h10 + i));
      tick();
      clear_inputs();
      n_tests++;
      if (pending_count !== 3'd5) begin
         n_fail++; $display("FAIL reset_load5: pending got %0d want 5", pending_count);
      end
      tick();
      n_tests++;
      if (pending_count !== 3'd3 || cdb_valid !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_before: pending %0d valid %b want 3 11", pending_count, cdb_valid);
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_data !== '0) begin
         n_fail++;
         $display("FAIL reset_async_lanes: valid %b tag %h data %h want 0", cdb_valid, cdb_tag,
                  cdb_data);
      end
      n_tests++;
      if (pending_count !== 3'd0 || dut.rr_ptr !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_async_state: pending %0d ptr %0d want 0 0", pending_count,
                  dut.rr_ptr);
      end
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 6'h3f || pending_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_release: ready %b pending %0d want 111111 0", req_ready,
                  pending_count);
      end
      tick();
   endtask

   task automatic test_single();
      do_reset();
      set_req(3, TW'(5), 32'hAA);
      tick();
      clear_inputs();
      n_tests++;
      if (cdb_valid !== 2'b00 || pending_count !== 3'd1) begin
         n_fail++;
         $display("FAIL single_cycle1: valid %b pending %0d want 00 1", cdb_valid, pending_count);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 2'b01 || cdb_tag[TW-1:0] !== TW'(5) || cdb_data[DW-1:0] !== 32'hAA) begin
         n_fail++;
         $display("FAIL single_cycle2: valid %b tag %0d data %h want 01 5 aa", cdb_valid,
                  cdb_tag[TW-1:0], cdb_data[DW-1:0]);
      end
      n_tests++;
      if (dut.rr_ptr !== 3'd4 || pending_count !== 3'd0) begin
         n_fail++;
         $display("FAIL single_ptr: ptr %0d pending %0d want 4 0", dut.rr_ptr, pending_count);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 2'b00) begin
         n_fail++; $display("FAIL single_one_cycle: valid %b want 00", cdb_valid);
      end
   endtask

   task automatic test_burst();
      logic [NC*TW-1:0] et;
      logic [NC*DW-1:0] ed;
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, TW'(i + 1), DW'(32'h100 + i));
      tick();
      clear_inputs();
      #1;
      n_tests++;
      if (pending_count !== 3'd6 || cdb_valid !== 2'b00 || req_ready !== 6'b000011) begin
         n_fail++;
         $display("FAIL burst_cycle1: pending %0d valid %b ready %b want 6 00 000011",
                  pending_count, cdb_valid, req_ready);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         et = {TW'(2 * c + 2), TW'(2 * c + 1)};
         ed = {DW'(32'h100 + 2 * c + 1), DW'(32'h100 + 2 * c)};
         n_tests++;
         if (cdb_valid !== 2'b11 || cdb_tag !== et || cdb_data !== ed) begin
            n_fail++;
            $display("FAIL burst_lanes%0d: valid %b tag %h data %h want 11 %h %h", c, cdb_valid,
                     cdb_tag, cdb_data, et, ed);
         end
         n_tests++;
         if (pending_count !== CW'(4 - 2 * c)) begin
            n_fail++;
            $display("FAIL burst_pending%0d: got %0d want %0d", c, pending_count, 4 - 2 * c);
         end
      end
      n_tests++;
      if (dut.rr_ptr !== 3'd0) begin
         n_fail++; $display("FAIL burst_ptr: got %0d want 0", dut.rr_ptr);
      end
   endtask

   task automatic test_squash();
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, TW'(i + 1), DW'(i));
      tick();
      clear_inputs();
      tick();
      n_tests++;
      if (pending_count !== 3'd4 || cdb_valid !== 2'b11 || dut.rr_ptr !== 3'd2) begin
         n_fail++;
         $display("FAIL squash_pre: pending %0d valid %b ptr %0d want 4 11 2", pending_count,
                  cdb_valid, dut.rr_ptr);
      end
      squash = 1'b1;
      set_req(0, TW'(7), 32'h77);
      #1;
      n_tests++;
      if (req_ready !== 6'b000000) begin
         n_fail++; $display("FAIL squash_ready: got %b want 000000", req_ready);
      end
      tick();
      clear_inputs();
      n_tests++;
      if (cdb_valid !== 2'b00 || pending_count !== 3'd0 || dut.rr_ptr !== 3'd2) begin
         n_fail++;
         $display("FAIL squash_after: valid %b pending %0d ptr %0d want 00 0 2", cdb_valid,
                  pending_count, dut.rr_ptr);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 2'b00 || pending_count !== 3'd0) begin
         n_fail++;
         $display("FAIL squash_no_accept: valid %b pending %0d want 00 0", cdb_valid,
                  pending_count);
      end
   endtask

   task automatic test_tag_zero();
      do_reset();
      set_req(2, TW'(0), 32'h22);
      set_req(4, TW'(9), 32'h99);
      tick();
      clear_inputs();
      #1;
      n_tests++;
      if (pending_count !== 3'd2 || req_ready !== 6'b111011) begin
         n_fail++;
         $display("FAIL tag0_cycle1: pending %0d ready %b want 2 111011", pending_count,
                  req_ready);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 2'b01 || cdb_tag[TW-1:0] !== TW'(9) || cdb_data[DW-1:0] !== 32'h99) begin
         n_fail++;
         $display("FAIL tag0_lane: valid %b tag %0d data %h want 01 9 99", cdb_valid,
                  cdb_tag[TW-1:0], cdb_data[DW-1:0]);
      end
      n_tests++;
      if (pending_count !== 3'd0 || dut.rr_ptr !== 3'd5) begin
         n_fail++;
         $display("FAIL tag0_slots: pending %0d ptr %0d want 0 5", pending_count, dut.rr_ptr);
      end
      tick();
      n_tests++;
      if (cdb_valid !== 2'b00) begin
         n_fail++; $display("FAIL tag0_never: valid %b want 00", cdb_valid);
      end
   endtask

   task automatic test_backpressure();
      int            seq [NR];
      int            got [NR];
      int            last [NR];
      logic [NR-1:0] mr;
      logic [TW-1:0] t;
      int            r;
      do_reset();
      for (int i = 0; i < NR; i++) begin
         seq[i] = 0; got[i] = 0; last[i] = -1;
      end
      for (int cyc = 0; cyc < 36; cyc++) begin
         clear_inputs();
         if (cyc < 30) begin
            for (int i = 0; i < NR; i++) set_req(i, TW'(i + 1), {16'(i), 16'(seq[i])});
         end
         #1;
         mr = model_ready();
         n_tests++;
         if (req_ready !== mr) begin
            n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", cyc, req_ready, mr);
         end
         for (int k = 0; k < NC; k++) begin
            if (cdb_valid[k]) begin
               t = cdb_tag[k*TW +: TW];
               r = int'(t) - 1;
               n_tests++;
               if (r < 0 || r >= NR) begin
                  n_fail++; $display("FAIL bp_tag c%0d: got %0d want 1..6", cyc, t);
               end else begin
                  if (cdb_data[k*DW +: DW] !== {16'(r), 16'(got[r])}) begin
                     n_fail++;
                     $display("FAIL bp_data c%0d: got %h want %h", cyc, cdb_data[k*DW +: DW],
                              {16'(r), 16'(got[r])});
                  end
                  got[r]++;
                  if (last[r] >= 0 && cyc <= 30) begin
                     n_tests++;
                     if (cyc - last[r] != 3) begin
                        n_fail++;
                        $display("FAIL bp_fair r%0d: gap got %0d want 3", r, cyc - last[r]);
                     end
                  end
                  last[r] = cyc;
               end
            end
         end
         tick();
         if (cyc < 30) for (int i = 0; i < NR; i++) if (mr[i]) seq[i]++;
      end
      for (int i = 0; i < NR; i++) begin
         n_tests++;
         if (got[i] != seq[i] || seq[i] < 8) begin
            n_fail++;
            $display("FAIL bp_scoreboard r%0d: broadcast %0d want accepted %0d (>=8)", i, got[i],
                     seq[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [NR-1:0]    mr;
      logic [NC-1:0]    ev;
      logic [NC*TW-1:0] etg;
      logic [NC*DW-1:0] edt;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         clear_inputs();
         req_valid = NR'($urandom);
         for (int i = 0; i < NR; i++) begin
            req_tag[i*TW +: TW]  = TW'($urandom_range(0, 7));
            req_data[i*DW +: DW] = $urandom;
         end
         squash = ($urandom_range(0, 15) == 0);
         #1;
         mr = model_ready();
         for (int k = 0; k < NC; k++) begin
            ev[k]            = lv[k];
            etg[k*TW +: TW]  = lt[k];
            edt[k*DW +: DW]  = ld[k];
         end
         n_tests++;
         if (req_ready !== mr) begin
            n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, req_ready, mr);
         end
         n_tests++;
         if (cdb_valid !== ev || cdb_tag !== etg || cdb_data !== edt) begin
            n_fail++;
            $display("FAIL rand_lanes c%0d: got %b %h %h want %b %h %h", cyc, cdb_valid, cdb_tag,
                     cdb_data, ev, etg, edt);
         end
         n_tests++;
         if (pending_count !== CW'(model_pending()) || dut.rr_ptr !== 3'(mptr)) begin
            n_fail++;
            $display("FAIL rand_state c%0d: pending %0d ptr %0d want %0d %0d", cyc,
                     pending_count, dut.rr_ptr, model_pending(), mptr);
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      test_reset();
      test_single();
      test_burst();
      test_squash();
      test_tag_zero();
      test_backpressure();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
